// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stalls, EX redirect flushes and bounded data-memory waits.
// Optional perf counters (stall_cnt/flush_cnt, CNT_W) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W          = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread_EX,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic             redirect_EX,
  input  logic             memop_MEM,
  input  logic             dmem_ack,
  input  logic             imem_valid,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             stall_IDEX,
  output logic             stall_EXMEM,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             dmem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MWAIT, MERR} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] tcnt, tcnt_nxt;
  logic            memwait, loaduse, redirect_win;

  assign memwait = memop_MEM & ~dmem_ack;
  assign loaduse = memread_EX && (rd_EX != 5'd0) &&
                   ((rs1_used_ID && (rs1_ID == rd_EX)) || (rs2_used_ID && (rs2_ID == rd_EX)));

  // NOTE: every signal gets a default before any branch, so no path can leave one unassigned (no latches).
  always_comb begin
    stall_PC     = 1'b0;
    stall_IFID   = 1'b0;
    stall_IDEX   = 1'b0;
    stall_EXMEM  = 1'b0;
    flush_IFID   = 1'b0;
    flush_IDEX   = 1'b0;
    dmem_timeout = 1'b0;
    redirect_win = 1'b0;
    state_nxt    = state;
    tcnt_nxt     = tcnt;

    if (!reset) begin
      // Inject bubbles while the pipeline is held in reset.
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end else begin
      dmem_timeout = (state == MERR);

      // The abandoned access in MERR must not re-freeze the pipeline.
      if ((state != MERR) && memwait) begin
        stall_PC    = 1'b1;
        stall_IFID  = 1'b1;
        stall_IDEX  = 1'b1;
        stall_EXMEM = 1'b1;
      end else if (redirect_EX) begin
        flush_IFID   = 1'b1;
        flush_IDEX   = 1'b1;
        redirect_win = 1'b1;
      end else if (loaduse) begin
        stall_PC   = 1'b1;
        stall_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end else if (!imem_valid) begin
        flush_IFID = 1'b1;
      end

      unique case (state)
        RUN: begin
          if (memwait) begin
            state_nxt = MWAIT;
            tcnt_nxt  = '0;
          end
        end
        MWAIT: begin
          if (dmem_ack)                                 state_nxt = RUN;
          else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1))   state_nxt = MERR;
          else                                          tcnt_nxt  = tcnt + 1'b1;
        end
        MERR:    state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_PC)     stall_cnt <= stall_cnt + 1'b1;
      if (redirect_win) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed spec scenarios then random traffic against a reference model.
// Perf counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_unit;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset, memread_EX, rs1_used_ID, rs2_used_ID, redirect_EX, memop_MEM, dmem_ack, imem_valid;
  logic [4:0] rd_EX, rs1_ID, rs2_ID;
  logic       stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, dmem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .memread_EX(memread_EX), .rd_EX(rd_EX),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .redirect_EX(redirect_EX), .memop_MEM(memop_MEM), .dmem_ack(dmem_ack), .imem_valid(imem_valid),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX), .stall_EXMEM(stall_EXMEM),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .dmem_timeout(dmem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic [6:0]  outs;
    int          cyc;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc;
    logic [31:0] fc;
`endif
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0, cyc = 0;

  // Reference model: a memory access that has been waiting for m_wait MWAIT-cycles (-1 = idle),
  // plus a flag that the previous access was just abandoned.
  int          m_wait = -1;
  bit          m_err  = 1'b0;
  logic [31:0] m_sc = '0, m_fc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
  endtask

  task automatic drive(input bit rst, input bit mr, input logic [4:0] rd, input logic [4:0] r1, input bit u1,
                       input logic [4:0] r2, input bit u2, input bit redir, input bit mop, input bit ack,
                       input bit iv);
    exp_t e;
    bit   lu, mw;
    logic [6:0] o;
    @(posedge clk); #1;
    reset = rst; memread_EX = mr; rd_EX = rd; rs1_ID = r1; rs1_used_ID = u1; rs2_ID = r2;
    rs2_used_ID = u2; redirect_EX = redir; memop_MEM = mop; dmem_ack = ack; imem_valid = iv;
    cyc++;

    lu = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    mw = !m_err && mop && !ack;
    o  = '0;  // {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, dmem_timeout}
    if (!rst) o = 7'b0000110;
    else begin
      o[0] = m_err;
      if (mw)         o[6:3] = 4'hF;
      else if (redir) o[2:1] = 2'b11;
      else if (lu)    begin o[6] = 1'b1; o[5] = 1'b1; o[1] = 1'b1; end
      else if (!iv)   o[2] = 1'b1;
    end
    e.outs = o;
    e.cyc  = cyc;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = m_sc;
    e.fc = m_fc;
`endif
    sb.push_back(e);

    if (!rst) begin
      m_sc = '0; m_fc = '0;
    end else begin
      m_sc = m_sc + {31'd0, o[6]};
      m_fc = m_fc + {31'd0, (redir && !mw)};
    end

    if (!rst || m_err) begin
      m_wait = -1; m_err = 1'b0;
    end else if (m_wait < 0) begin
      if (mw) m_wait = 0;
    end else if (ack) begin
      m_wait = -1;
    end else if (m_wait == T - 1) begin
      m_wait = -1; m_err = 1'b1;
    end else begin
      m_wait++;
    end
  endtask

  // Plain cycle: no hazards, fetch valid.
  task automatic idle(input bit rst);
    drive(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("outputs", {25'd0, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX,
                          dmem_timeout}, {25'd0, e.outs}, e.cyc);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, e.sc, e.cyc);
        check("flush_cnt", flush_cnt, e.fc, e.cyc);
`endif
      end
    end
  end

  initial begin
    reset = 0; memread_EX = 0; rd_EX = 0; rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
    redirect_EX = 0; memop_MEM = 0; dmem_ack = 0; imem_valid = 1;

    idle(0); idle(0); idle(1);
    // load-use on rs1, then same with rd_EX = x0
    drive(1, 1, 5, 5, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    // redirect together with load-use, then fetch bubble
    drive(1, 1, 5, 5, 1, 5, 1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ack after 3 waiting cycles
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    // zero-wait access
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    // timeout: 5 stalled cycles then one dmem_timeout cycle, then back-to-back wait
    repeat (6) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    // redirect masked by memwait, ack, then redirect flush
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    // reset mid-wait with tcnt=2: no timeout pulse afterwards
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    repeat (6) idle(1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) != 0, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
